lsu_apb_dmem: RTL and testbench



---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_dmem_sram.sv | 30 +++
 rtl/lsu_apb_dmem.sv | 161 ++++++++++++++++
 tb/tb_lsu_apb_dmem.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and decode helpers for the LSU data memory
package lsu_pkg;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct);
    case (funct)
      F_B, F_BU: return 3'd1;
      F_H, F_HU: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] funct, input logic write);
    case (funct)
      F_B, F_H, F_W: return 1'b1;
      F_BU, F_HU:    return !write;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_sram.sv
// rtl/lsu_dmem_sram.sv - single-port word SRAM with byte enables and one-cycle registered read
module lsu_dmem_sram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata only changes on a read, so it holds the last read word until the next one
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lsu_apb_dmem.sv
// rtl/lsu_apb_dmem.sv - APB-slave data memory for the LSU; splits word-crossing accesses into two SRAM ops
module lsu_apb_dmem
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 10,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [2:0]        pfunct_code_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t state, state_n;

  logic [AW-1:0] widx_q;
  logic [1:0]    off_q;
  logic [2:0]    funct_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic          span_q;
  logic [31:0]   lowbuf_q;

  logic          sram_en, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;

  // Request decode, evaluated on the setup cycle so errors are known before any SRAM op
  logic              setup;
  logic [ADDR_W-1:0] widx_in;
  logic [3:0]        end_in;
  logic              span_in, err_in;

  assign setup   = psel_i & ~penable_i;
  assign widx_in = {2'b00, paddr_i[ADDR_W-1:2]};
  assign end_in  = {2'b00, paddr_i[1:0]} + {1'b0, size_of(pfunct_code_i)};
  assign span_in = end_in > 4'd4;
  assign err_in  = !is_legal(pfunct_code_i, pwrite_i)
                || (widx_in >= ADDR_W'(DEPTH_WORDS))
                || (span_in && ((MISALIGN_EN == 0)
                                || (widx_in + ADDR_W'(1) >= ADDR_W'(DEPTH_WORDS))));

  logic [63:0] data64;
  logic [7:0]  strb8;
  logic [3:0]  base_strb;
  logic [63:0] raw64;
  logic [31:0] ld_word;

  always_comb begin
    base_strb = 4'b1111;
    case (size_of(funct_q))
      3'd1:    base_strb = 4'b0001;
      3'd2:    base_strb = 4'b0011;
      default: base_strb = 4'b1111;
    endcase
  end

  assign data64  = {32'b0, wdata_q} << {off_q, 3'b000};
  assign strb8   = {4'b0000, base_strb} << off_q;
  assign raw64   = span_q ? {sram_rdata, lowbuf_q} : {32'b0, sram_rdata};
  assign ld_word = 32'(raw64 >> {off_q, 3'b000});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      widx_q   <= '0;
      off_q    <= '0;
      funct_q  <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      span_q   <= 1'b0;
      lowbuf_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && setup) begin
        widx_q  <= paddr_i[AW+1:2];
        off_q   <= paddr_i[1:0];
        funct_q <= pfunct_code_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        err_q   <= err_in;
        span_q  <= span_in;
      end
      if (state == S_ACC1) lowbuf_q <= sram_rdata;
    end
  end

  always_comb begin
    state_n    = state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = widx_q;
    sram_wdata = '0;
    pready_o   = 1'b0;
    pslverr_o  = 1'b0;
    prdata_o   = '0;
    case (state)
      S_IDLE: begin
        if (setup) state_n = err_in ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        sram_en    = 1'b1;
        sram_we    = write_q;
        sram_be    = strb8[3:0];
        sram_wdata = data64[31:0];
        state_n    = span_q ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        sram_en    = 1'b1;
        sram_we    = write_q;
        sram_be    = strb8[7:4];
        sram_addr  = widx_q + AW'(1);
        sram_wdata = data64[63:32];
        state_n    = S_RESP;
      end
      S_RESP: begin
        pready_o  = 1'b1;
        pslverr_o = err_q;
        if (!err_q && !write_q) begin
          case (funct_q)
            F_B:     prdata_o = {{24{ld_word[7]}}, ld_word[7:0]};
            F_H:     prdata_o = {{16{ld_word[15]}}, ld_word[15:0]};
            F_BU:    prdata_o = {24'b0, ld_word[7:0]};
            F_HU:    prdata_o = {16'b0, ld_word[15:0]};
            default: prdata_o = ld_word;
          endcase
        end
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  lsu_dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk_i),
    .en   (sram_en),
    .we   (sram_we),
    .be   (sram_be),
    .addr (sram_addr),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

endmodule

// File: tb/tb_lsu_apb_dmem.sv
// tb/tb_lsu_apb_dmem.sv - directed self-checking bench for lsu_apb_dmem
module tb_lsu_apb_dmem;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [2:0]  pfunct;
  logic [31:0] prd_m, prd_a;
  logic        rdy_m, rdy_a, err_m, err_a;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_apb_dmem #(.DEPTH_WORDS(64), .ADDR_W(10), .MISALIGN_EN(1)) dut_m (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pfunct_code_i(pfunct),
    .prdata_o(prd_m), .pready_o(rdy_m), .pslverr_o(err_m));

  lsu_apb_dmem #(.DEPTH_WORDS(64), .ADDR_W(10), .MISALIGN_EN(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pfunct_code_i(pfunct),
    .prdata_o(prd_a), .pready_o(rdy_a), .pslverr_o(err_a));

  // which = 0 watches the misalign-capable instance, 1 the aligned-only one
  task automatic apb(input bit which, input bit wr, input logic [9:0] addr, input logic [2:0] f,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    logic rdy;
    repeat (2) @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pfunct = f; pwdata = wd;
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      penable = 1'b1;
      rdy = which ? rdy_a : rdy_m;
      if (rdy) begin
        lat = k;
        rd  = which ? prd_a : prd_m;
        er  = which ? err_a : err_m;
      end
    end
    n_chk++;
    if (lat == 0) begin n_fail++; $display("FAIL apb_timeout addr=%h got no pready exp pready", addr); end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pfunct = '0;
    repeat (2) @(negedge clk);
    n_chk++; if ({rdy_m, err_m, prd_m} !== 34'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", {rdy_m, err_m, prd_m}); end
    rst = 1'b0;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; logic er; int lat;
    apb(0, 1, 10'h010, F_W, 32'hDEADBEEF, rd, er, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency got %0d exp 2", lat); end
    apb(0, 0, 10'h010, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", rd); end
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b exp 0", er); end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency got %0d exp 2", lat); end
    @(negedge clk);
    n_chk++; if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL pready_one_cycle got %b exp 0", rdy_m); end
  endtask

  task automatic test_byte_ext();
    logic [31:0] rd; logic er; int lat;
    apb(0, 1, 10'h010, F_W, 32'h0, rd, er, lat);
    apb(0, 1, 10'h013, F_B, 32'h00000080, rd, er, lat);
    apb(0, 0, 10'h010, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL sb_then_lw got %h exp 80000000", rd); end
    apb(0, 0, 10'h013, F_B, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sign got %h exp ffffff80", rd); end
    apb(0, 0, 10'h013, F_BU, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero got %h exp 00000080", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    apb(0, 1, 10'h00E, F_W, 32'h11223344, rd, er, lat);
    n_chk++; if (lat != 3 || er !== 1'b0) begin n_fail++; $display("FAIL span_sw got lat=%0d err=%b exp lat=3 err=0", lat, er); end
    apb(0, 0, 10'h00E, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL span_lw got %h exp 11223344", rd); end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL span_lw_latency got %0d exp 3", lat); end
    apb(0, 0, 10'h00F, F_H, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h00002233) begin n_fail++; $display("FAIL span_lh got %h exp 00002233", rd); end
    apb(0, 0, 10'h010, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h80001122) begin n_fail++; $display("FAIL span_word1_bytes got %h exp 80001122", rd); end
  endtask

  task automatic test_range_err();
    logic [31:0] rd; logic er; int lat;
    apb(0, 1, 10'h0FC, F_W, 32'hCAFEF00D, rd, er, lat);
    apb(0, 1, 10'h000, F_W, 32'h12345678, rd, er, lat);
    apb(0, 0, 10'h100, F_W, 32'h0, rd, er, lat);
    n_chk++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL oob_lw got err=%b data=%h exp err=1 data=0", er, rd); end
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL oob_latency got %0d exp 1", lat); end
    apb(0, 1, 10'h0FE, F_W, 32'h99999999, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL end_span_sw got err=%b lat=%0d exp err=1 lat=1", er, lat); end
    apb(0, 0, 10'h0FC, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL word63_kept got %h exp cafef00d", rd); end
    apb(0, 0, 10'h000, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL word0_kept got %h exp 12345678", rd); end
  endtask

  task automatic test_funct_err();
    logic [31:0] rd; logic er; int lat;
    apb(0, 0, 10'h010, 3'b011, 32'h0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL funct011_load got err=%b lat=%0d exp err=1 lat=1", er, lat); end
    apb(0, 1, 10'h010, 3'b100, 32'hFFFFFFFF, rd, er, lat);
    n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL funct100_store got err=%b exp 1", er); end
    apb(0, 0, 10'h010, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h80001122) begin n_fail++; $display("FAIL bad_store_no_write got %h exp 80001122", rd); end
  endtask

  task automatic test_no_misalign();
    logic [31:0] rd; logic er; int lat;
    apb(1, 0, 10'h003, F_H, 32'h0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL nomis_lh3 got err=%b lat=%0d exp err=1 lat=1", er, lat); end
    apb(1, 0, 10'h002, F_H, 32'h0, rd, er, lat);
    n_chk++; if ({er, rd} !== {1'b0, 32'h00001234}) begin n_fail++; $display("FAIL nomis_lh2 got err=%b data=%h exp err=0 data=00001234", er, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit seen;
    apb(0, 1, 10'h020, F_W, 32'h01020304, rd, er, lat);
    apb(0, 1, 10'h024, F_W, 32'h05060708, rd, er, lat);
    repeat (2) @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h023; pfunct = F_W; pwdata = 32'hAABBCCDD;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL acc1_no_ready got %b exp 0", rdy_m); end
    rst = 1'b1;
    #1;
    n_chk++; if ({rdy_m, err_m, prd_m} !== 34'd0) begin n_fail++; $display("FAIL mid_reset_outputs got %h exp 0", {rdy_m, err_m, prd_m}); end
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (rdy_m) seen = 1; end
    n_chk++; if (seen) begin n_fail++; $display("FAIL mid_reset_no_pready got 1 exp 0"); end
    apb(0, 0, 10'h020, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'hDD020304) begin n_fail++; $display("FAIL reset_word0_written got %h exp dd020304", rd); end
    apb(0, 0, 10'h024, F_W, 32'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h05060708) begin n_fail++; $display("FAIL reset_word1_kept got %h exp 05060708", rd); end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_ext();
    test_misaligned();
    test_range_err();
    test_funct_err();
    test_no_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
